// File: rtl/md_pkg.sv
// md_pkg: shared packet type, constants and FSM states for the force cache
package md_pkg;
    localparam int PKT_W = 97;
    localparam int NULL_BIT = 96;
    typedef logic [PKT_W-1:0] pkt_t;
    localparam pkt_t NULL_PKT = {1'b1, 96'b0};
    localparam pkt_t ZERO_PKT = '0;
    typedef enum logic [1:0] {INIT, ACCUM, DRAIN_WAIT, DRAIN} state_t;
    function automatic pkt_t live_pkt(input pkt_t p);
        return p & ~NULL_PKT;
    endfunction
endpackage

// File: rtl/force_bram.sv
// force_bram: simple dual-port force cache, synchronous read, no reset on contents
module force_bram
    import md_pkg::*;
#(
    parameter int DEPTH = 256,
    localparam int IW = $clog2(DEPTH)
) (
    input  logic          clk,
    input  logic [IW-1:0] rd_addr,
    output pkt_t          rd_data,
    input  logic          wr_en,
    input  logic [IW-1:0] wr_addr,
    input  pkt_t          wr_data
);
    pkt_t mem [DEPTH];
    // one read and one write per cycle; same-address overlap is kept out by the caller
    always_ff @(posedge clk) begin
        rd_data <= mem[rd_addr];
        if (wr_en) mem[wr_addr] <= wr_data;
    end
endmodule

// File: rtl/force_accum_rmw.sv
// force_accum_rmw: read-modify-write accumulator front end for the Adder, with init and drain
module force_accum_rmw
    import md_pkg::*;
#(
    parameter int DEPTH = 256,
    localparam int IW = $clog2(DEPTH)
) (
    input  logic             clk,
    input  logic             reset_n,
    input  logic             in_valid,
    output logic             in_ready,
    input  logic [IW-1:0]    in_idx,
    input  logic [PKT_W-1:0] in_force,
    output logic [PKT_W-1:0] add_a,
    output logic [PKT_W-1:0] add_b,
    input  logic [PKT_W-1:0] add_o,
    input  logic             add_en,
    input  logic             drain_start,
    output logic             drain_busy,
    output logic             out_valid,
    input  logic             out_ready,
    output logic [IW-1:0]    out_idx,
    output logic [PKT_W-1:0] out_force,
    output logic             err_null_sum
);
    state_t state, state_nx;
    logic [IW-1:0] init_cnt, rd_cnt, pend_idx, pf_idx, rd_addr, wr_addr;
    logic [IW-1:0] s1_idx, s2_idx, s3_idx;
    logic s1_v, s2_v, s3_v, s3_en, s3_ok;
    pkt_t s3_o, rd_data, wr_data, pf_f;
    logic rd_done, rd_pend, pf_v, wr_en;
    logic hazard, live, fire, last, issue;
    logic [1:0] occ;

    force_bram #(.DEPTH(DEPTH)) u_bram (
        .clk    (clk),
        .rd_addr(rd_addr),
        .rd_data(rd_data),
        .wr_en  (wr_en),
        .wr_addr(wr_addr),
        .wr_data(wr_data)
    );

    // next state, handshakes, and the shared BRAM port muxing
    always_comb begin
        hazard = (s1_v && s1_idx == in_idx) || (s2_v && s2_idx == in_idx) || (s3_v && s3_idx == in_idx);
        in_ready = state == ACCUM && !hazard;
        live = in_valid && in_ready && !in_force[NULL_BIT];
        fire = out_valid && out_ready;
        last = fire && out_idx == IW'(DEPTH - 1);
        occ = 2'(out_valid) + 2'(pf_v) + 2'(rd_pend);
        issue = state == DRAIN && !rd_done && (occ - 2'(fire)) < 2'd2;
        s3_ok = s3_v && s3_en && !s3_o[NULL_BIT];
        rd_addr = state == DRAIN ? rd_cnt : in_idx;
        wr_en = state == INIT || (state == DRAIN ? fire : s3_ok);
        wr_addr = state == INIT ? init_cnt : state == DRAIN ? out_idx : s3_idx;
        wr_data = (state == INIT || state == DRAIN) ? ZERO_PKT : live_pkt(s3_o);
        state_nx = state;
        case (state)
            INIT:       state_nx = init_cnt == IW'(DEPTH - 1) ? ACCUM : INIT;
            ACCUM:      state_nx = drain_start ? DRAIN_WAIT : ACCUM;
            DRAIN_WAIT: state_nx = (s1_v || s2_v || s3_v) ? DRAIN_WAIT : DRAIN;
            DRAIN:      state_nx = last ? ACCUM : DRAIN;
            default:    state_nx = INIT;
        endcase
    end

    // state register
    always_ff @(posedge clk or negedge reset_n) begin
        if (!reset_n) state <= INIT;
        else state <= state_nx;
    end

    // post-reset zeroing sweep address
    always_ff @(posedge clk or negedge reset_n) begin
        if (!reset_n) init_cnt <= '0;
        else init_cnt <= state == INIT ? init_cnt + 1'b1 : '0;
    end

    // accumulate pipeline: s1 read issued, s2 old sum to add_b, s3 Adder result written back
    always_ff @(posedge clk or negedge reset_n) begin
        if (!reset_n) begin
            {s1_v, s2_v, s3_v, s3_en, err_null_sum} <= '0;
            {s1_idx, s2_idx, s3_idx} <= '0;
            add_a <= NULL_PKT;
            add_b <= NULL_PKT;
            s3_o <= NULL_PKT;
        end else begin
            s1_v <= live;
            s1_idx <= in_idx;
            add_a <= live ? live_pkt(in_force) : NULL_PKT;
            s2_v <= s1_v;
            s2_idx <= s1_idx;
            add_b <= s1_v ? live_pkt(rd_data) : NULL_PKT;
            s3_v <= s2_v;
            s3_idx <= s2_idx;
            s3_o <= add_o;
            s3_en <= add_en;
            if (s3_v && !s3_ok) err_null_sum <= 1'b1;
        end
    end

    // drain: sequential reads into a registered output with a one-entry prefetch buffer
    always_ff @(posedge clk or negedge reset_n) begin
        if (!reset_n) begin
            {drain_busy, out_valid, pf_v, rd_pend, rd_done} <= '0;
            {rd_cnt, pend_idx, pf_idx, out_idx} <= '0;
            out_force <= ZERO_PKT;
            pf_f <= ZERO_PKT;
        end else begin
            if (state == ACCUM && drain_start) begin
                drain_busy <= 1'b1;
                rd_cnt <= '0;
                rd_done <= 1'b0;
            end else if (last) drain_busy <= 1'b0;
            if (issue) begin
                rd_cnt <= rd_cnt + 1'b1;
                rd_done <= rd_cnt == IW'(DEPTH - 1);
            end
            rd_pend <= issue;
            pend_idx <= rd_cnt;
            if (!out_valid || fire) begin
                out_valid <= pf_v || rd_pend;
                out_idx <= pf_v ? pf_idx : pend_idx;
                out_force <= pf_v ? pf_f : live_pkt(rd_data);
                pf_v <= pf_v && rd_pend;
                pf_idx <= pend_idx;
                pf_f <= live_pkt(rd_data);
            end else if (rd_pend) begin
                pf_v <= 1'b1;
                pf_idx <= pend_idx;
                pf_f <= live_pkt(rd_data);
            end
        end
    end
endmodule

// File: tb/tb_force_accum_rmw.sv
// tb_force_accum_rmw: directed checks of accumulate, hazard stall, null handling, drain and reset
module tb_force_accum_rmw;
    import md_pkg::*;
    localparam int DEPTH = 256;
    localparam int IW = 8;
    localparam logic [31:0] F_HALF = 32'h3F000000, F_ONE = 32'h3F800000;
    localparam logic [31:0] F_1P5 = 32'h3FC00000, F_TWO = 32'h40000000, F_THREE = 32'h40400000;

    logic clk, reset_n, in_valid, in_ready, add_en, drain_start, drain_busy;
    logic out_valid, out_ready, err_null_sum, kill_en;
    logic [IW-1:0] in_idx, out_idx;
    logic [96:0] in_force, add_a, add_b, add_o, out_force;
    logic [96:0] a_q = NULL_PKT;
    logic [96:0] exp_mem [DEPTH];
    int checks = 0, errors = 0, w;

    force_accum_rmw #(.DEPTH(DEPTH)) dut (
        .clk(clk), .reset_n(reset_n), .in_valid(in_valid), .in_ready(in_ready),
        .in_idx(in_idx), .in_force(in_force), .add_a(add_a), .add_b(add_b),
        .add_o(add_o), .add_en(add_en), .drain_start(drain_start), .drain_busy(drain_busy),
        .out_valid(out_valid), .out_ready(out_ready), .out_idx(out_idx),
        .out_force(out_force), .err_null_sum(err_null_sum)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    function automatic real f2r(input logic [31:0] f);
        logic [10:0] e;
        if (f[30:0] == 31'b0) return 0.0;
        e = {3'b0, f[30:23]} + 11'd896;
        return $bitstoreal({f[31], e, f[22:0], 29'b0});
    endfunction

    function automatic logic [31:0] r2f(input real r);
        logic [63:0] d;
        logic [10:0] e;
        d = $realtobits(r);
        if (d[62:0] == 63'b0) return 32'b0;
        e = d[62:52] - 11'd896;
        return {d[63], e[7:0], d[51:29]};
    endfunction

    function automatic logic [95:0] fadd3(input logic [95:0] a, input logic [95:0] b);
        return {r2f(f2r(a[95:64]) + f2r(b[95:64])), r2f(f2r(a[63:32]) + f2r(b[63:32])),
                r2f(f2r(a[31:0]) + f2r(b[31:0]))};
    endfunction

    function automatic logic [96:0] mk(input logic [31:0] x, input logic [31:0] y, input logic [31:0] z);
        return {1'b0, z, y, x};
    endfunction

    // Adder stand-in: a is taken one cycle before b, result is combinational on the b cycle
    always @(posedge clk) a_q <= add_a;
    always_comb begin
        add_en = !a_q[96] && !add_b[96] && !kill_en;
        add_o = add_en ? {1'b0, fadd3(a_q[95:0], add_b[95:0])} : NULL_PKT;
    end

    task automatic check(input string tag, input logic [96:0] got, input logic [96:0] exp);
        checks++;
        if (got !== exp) begin
            errors++;
            $display("FAIL %s got=%h exp=%h", tag, got, exp);
        end
    endtask

    task automatic send(input logic [IW-1:0] idx, input logic [96:0] f, output int waits);
        in_valid = 1'b1;
        in_idx = idx;
        in_force = f;
        waits = 0;
        #1;
        while (!in_ready && waits < 20) begin
            @(negedge clk);
            #1;
            waits++;
        end
        check("send_ready", 97'(in_ready), 97'(1));
        @(negedge clk);
    endtask

    task automatic wait_init();
        int n = 0;
        while (!in_ready && n < 2 * DEPTH + 20) begin
            @(negedge clk);
            n++;
        end
        check("init_ready", 97'(in_ready), 97'(1));
    endtask

    task automatic do_drain(input bit stall);
        int k = 0, cyc = 0;
        logic held = 1'b0;
        logic [IW-1:0] h_idx = '0;
        logic [96:0] h_f = '0;
        @(negedge clk);
        drain_start = 1'b1;
        @(negedge clk);
        drain_start = 1'b0;
        check("drain_busy_on", 97'(drain_busy), 97'(1));
        while (k < DEPTH && cyc < 4 * DEPTH + 50) begin
            out_ready = !stall || (cyc % 3 == 0);
            if (held) begin
                check("stall_valid", 97'(out_valid), 97'(1));
                check("stall_idx", 97'(out_idx), 97'(h_idx));
                check("stall_force", out_force, h_f);
            end
            held = out_valid && !out_ready;
            h_idx = out_idx;
            h_f = out_force;
            if (out_valid && out_ready) begin
                check($sformatf("drain_idx[%0d]", k), 97'(out_idx), 97'(k));
                check($sformatf("drain_force[%0d]", k), out_force, exp_mem[k]);
                exp_mem[k] = '0;
                k++;
            end
            @(negedge clk);
            cyc++;
        end
        out_ready = 1'b0;
        check("drain_beats", 97'(k), 97'(DEPTH));
        check("drain_busy_off", 97'(drain_busy), 97'(0));
        check("drain_valid_off", 97'(out_valid), 97'(0));
    endtask

    initial begin
        reset_n = 1'b0;
        {in_valid, drain_start, out_ready, kill_en} = '0;
        in_idx = '0;
        in_force = '0;
        foreach (exp_mem[i]) exp_mem[i] = '0;
        repeat (3) @(negedge clk);
        check("rst_in_ready", 97'(in_ready), 97'(0));
        check("rst_out_valid", 97'(out_valid), 97'(0));
        check("rst_busy", 97'(drain_busy), 97'(0));
        check("rst_err", 97'(err_null_sum), 97'(0));
        check("rst_add_a", add_a, NULL_PKT);
        check("rst_add_b", add_b, NULL_PKT);
        reset_n = 1'b1;
        drain_start = 1'b1;
        @(negedge clk);
        drain_start = 1'b0;
        check("init_no_ready", 97'(in_ready), 97'(0));
        check("init_drain_ignored", 97'(drain_busy), 97'(0));
        wait_init();
        do_drain(1'b0);
        check("t1_err", 97'(err_null_sum), 97'(0));

        send(8'd5, mk(F_ONE, 0, 0), w);
        check("t2_add_a_first", add_a, mk(F_ONE, 0, 0));
        send(8'd9, mk(F_TWO, 0, 0), w);
        in_valid = 1'b0;
        check("t2_no_wait", 97'(w), 97'(0));
        check("t2_add_b_old", add_b, ZERO_PKT);
        check("t2_add_a_second", add_a, mk(F_TWO, 0, 0));
        exp_mem[5] = mk(F_ONE, 0, 0);
        exp_mem[9] = mk(F_TWO, 0, 0);
        do_drain(1'b0);

        send(8'd7, mk(F_ONE, 0, 0), w);
        send(8'd7, mk(F_HALF, 0, 0), w);
        check("t3_wait2", 97'(w), 97'(3));
        send(8'd7, mk(F_1P5, 0, 0), w);
        in_valid = 1'b0;
        check("t3_wait3", 97'(w), 97'(3));
        exp_mem[7] = mk(F_THREE, 0, 0);
        do_drain(1'b0);

        send(8'd3, {1'b1, 96'h0000_0000_4000_0000_3F80_0000}, w);
        check("t4_null_add_a", add_a, NULL_PKT);
        send(8'd3, mk(0, F_TWO, 0), w);
        in_valid = 1'b0;
        check("t4_no_wait", 97'(w), 97'(0));
        exp_mem[3] = mk(0, F_TWO, 0);
        do_drain(1'b1);
        do_drain(1'b0);
        check("t5_err", 97'(err_null_sum), 97'(0));

        send(8'd200, mk(F_ONE, 0, 0), w);
        in_valid = 1'b0;
        @(negedge clk);
        drain_start = 1'b1;
        out_ready = 1'b1;
        @(negedge clk);
        drain_start = 1'b0;
        repeat (20) @(negedge clk);
        check("t6_mid_busy", 97'(drain_busy), 97'(1));
        #2 reset_n = 1'b0;
        #1;
        check("t6_rst_valid", 97'(out_valid), 97'(0));
        check("t6_rst_busy", 97'(drain_busy), 97'(0));
        check("t6_rst_ready", 97'(in_ready), 97'(0));
        @(negedge clk);
        reset_n = 1'b1;
        out_ready = 1'b0;
        wait_init();
        do_drain(1'b0);
        check("t6_busy_idle", 97'(drain_busy), 97'(0));

        kill_en = 1'b1;
        send(8'd10, mk(F_ONE, 0, 0), w);
        in_valid = 1'b0;
        repeat (4) @(negedge clk);
        kill_en = 1'b0;
        check("t6_err_set", 97'(err_null_sum), 97'(1));
        send(8'd11, mk(F_ONE, 0, 0), w);
        in_valid = 1'b0;
        exp_mem[11] = mk(F_ONE, 0, 0);
        do_drain(1'b0);
        check("t6_err_sticky", 97'(err_null_sum), 97'(1));
        reset_n = 1'b0;
        #1;
        check("t6_err_cleared", 97'(err_null_sum), 97'(0));
        @(negedge clk);
        reset_n = 1'b1;
        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end
endmodule
